// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive packet controller.
//   state_t           controller FSM states
//   ERR_*             err_code values reported alongside pkt_err
//   DEFAULT_SYNC_BYTE default start-of-packet marker
package uart_rx_pkg;

  typedef enum logic [2:0] {
    DISABLED = 3'd0,
    HUNT     = 3'd1,
    LEN      = 3'd2,
    PAYLOAD  = 3'd3,
    CSUM     = 3'd4,
    DRAIN    = 3'd5
  } state_t;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_FRAME   = 3'd1;
  localparam logic [2:0] ERR_PARITY  = 3'd2;
  localparam logic [2:0] ERR_LENGTH  = 3'd3;
  localparam logic [2:0] ERR_CSUM    = 3'd4;
  localparam logic [2:0] ERR_TIMEOUT = 3'd5;
  localparam logic [2:0] ERR_OVERRUN = 3'd6;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_rx_pkt_buf.sv
// Payload buffer: DEPTH x 8 storage, one synchronous write port and one
// read port with registered read data (data appears the cycle after rd_addr).
//   clock    in   system clock
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_addr  in   read address
//   rd_data  out  registered read data
module uart_rx_pkt_buf #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clock,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/uart_rx_packet_ctrl.sv
// Packet framer between uart_receiver and the system. Frames bytes as
// SYNC, LEN, PAYLOAD[LEN], CSUM (xor of LEN and payload), buffers the payload
// and releases it on a valid/ready stream only once the checksum matches.
// Optional statistics counters are built when UART_RX_STATS_EN is defined.
//   clock, reset         system clock, synchronous active-low reset
//   cfg_enable, cfg_baud controller enable, baud code
//   baud_select, Rx_EN   controls to uart_receiver
//   Rx_DATA/VALID/FERROR/PERROR  byte strobe and status from uart_receiver
//   pkt_data/valid/ready/last    payload stream
//   pkt_done, pkt_err, err_code  packet completion / abort pulses
//   stat_ok, stat_err    saturating good / error packet counts
module uart_rx_packet_ctrl
  import uart_rx_pkg::*;
#(
  parameter int unsigned MAX_LEN     = 16,
  parameter logic [7:0]  SYNC_BYTE   = DEFAULT_SYNC_BYTE,
  parameter int unsigned TIMEOUT_CYC = 20000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cfg_enable,
  input  logic [2:0]  cfg_baud,
  output logic [2:0]  baud_select,
  output logic        Rx_EN,
  input  logic [7:0]  Rx_DATA,
  input  logic        Rx_VALID,
  input  logic        Rx_FERROR,
  input  logic        Rx_PERROR,
  output logic [7:0]  pkt_data,
  output logic        pkt_valid,
  input  logic        pkt_ready,
  output logic        pkt_last,
  output logic        pkt_done,
  output logic        pkt_err,
  output logic [2:0]  err_code,
  output logic [15:0] stat_ok,
  output logic [15:0] stat_err
);

  localparam int unsigned AW         = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TW         = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [7:0]  MAX_LEN8   = 8'(MAX_LEN);

  state_t        state_q, state_n;
  logic          rx_valid_q;
  logic [7:0]    len_q, len_n;
  logic [7:0]    idx_q, idx_n;
  logic [7:0]    xor_q, xor_n;
  logic [7:0]    rd_ptr_q, rd_ptr_n;
  logic [TW-1:0] timer_q, timer_n;
  logic [7:0]    data_n;
  logic          valid_n, last_n, done_n, err_n;
  logic [2:0]    code_n;
  logic          wr_en;
  logic [7:0]    rd_data;
  logic          byte_ev, byte_bad;

  assign byte_ev  = Rx_VALID & ~rx_valid_q;
  assign byte_bad = Rx_FERROR | Rx_PERROR;

  // Read address is the next-cycle pointer, so rd_data always holds
  // buffer[rd_ptr_q]; this lets DRAIN reload pkt_data on the transfer edge.
  uart_rx_pkt_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_addr (AW'(idx_q)),
    .wr_data (Rx_DATA),
    .rd_addr (AW'(rd_ptr_n)),
    .rd_data (rd_data)
  );

  always_comb begin
    state_n  = state_q;
    len_n    = len_q;
    idx_n    = idx_q;
    xor_n    = xor_q;
    rd_ptr_n = '0;
    timer_n  = '0;
    data_n   = pkt_data;
    valid_n  = pkt_valid;
    last_n   = pkt_last;
    done_n   = 1'b0;
    err_n    = 1'b0;
    code_n   = ERR_NONE;
    wr_en    = 1'b0;
    case (state_q)
      DISABLED: begin
        if (cfg_enable) state_n = HUNT;
      end
      HUNT: begin
        if (!cfg_enable) begin
          state_n = DISABLED;
        end else if (byte_ev && !byte_bad && Rx_DATA == SYNC_BYTE) begin
          state_n = LEN;
        end
      end
      LEN, PAYLOAD, CSUM: begin
        timer_n = byte_ev ? '0 : timer_q + 1'b1;
        if (!cfg_enable) begin
          state_n = DISABLED;
        end else if (byte_ev) begin
          if (byte_bad) begin
            err_n   = 1'b1;
            code_n  = Rx_FERROR ? ERR_FRAME : ERR_PARITY;
            state_n = HUNT;
          end else if (state_q == LEN) begin
            len_n = Rx_DATA;
            xor_n = Rx_DATA;
            idx_n = '0;
            if (Rx_DATA > MAX_LEN8) begin
              err_n   = 1'b1;
              code_n  = ERR_LENGTH;
              state_n = HUNT;
            end else if (Rx_DATA == 8'd0) begin
              state_n = CSUM;
            end else begin
              state_n = PAYLOAD;
            end
          end else if (state_q == PAYLOAD) begin
            wr_en = 1'b1;
            xor_n = xor_q ^ Rx_DATA;
            idx_n = idx_q + 8'd1;
            if (idx_q == len_q - 8'd1) state_n = CSUM;
          end else begin
            if (Rx_DATA != xor_q) begin
              err_n   = 1'b1;
              code_n  = ERR_CSUM;
              state_n = HUNT;
            end else if (len_q == 8'd0) begin
              done_n  = 1'b1;
              state_n = HUNT;
            end else begin
              state_n = DRAIN;
            end
          end
        end else if (timer_q == TIMER_LAST) begin
          err_n   = 1'b1;
          code_n  = ERR_TIMEOUT;
          state_n = HUNT;
        end
      end
      DRAIN: begin
        rd_ptr_n = rd_ptr_q;
        if (byte_ev) begin
          err_n  = 1'b1;
          code_n = ERR_OVERRUN;
        end
        if (!pkt_valid || pkt_ready) begin
          if (pkt_valid && pkt_last) begin
            valid_n = 1'b0;
            last_n  = 1'b0;
            done_n  = 1'b1;
            state_n = cfg_enable ? HUNT : DISABLED;
          end else begin
            // First DRAIN cycle or a beat just transferred: load the next beat.
            data_n  = rd_data;
            valid_n = 1'b1;
            last_n  = (rd_ptr_q == len_q - 8'd1);
            if (rd_ptr_q != len_q - 8'd1) rd_ptr_n = rd_ptr_q + 8'd1;
          end
        end
      end
      default: state_n = DISABLED;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= DISABLED;
      rx_valid_q  <= 1'b0;
      len_q       <= '0;
      idx_q       <= '0;
      xor_q       <= '0;
      rd_ptr_q    <= '0;
      timer_q     <= '0;
      pkt_data    <= '0;
      pkt_valid   <= 1'b0;
      pkt_last    <= 1'b0;
      pkt_done    <= 1'b0;
      pkt_err     <= 1'b0;
      err_code    <= ERR_NONE;
      Rx_EN       <= 1'b0;
      baud_select <= '0;
    end else begin
      state_q    <= state_n;
      rx_valid_q <= Rx_VALID;
      len_q      <= len_n;
      idx_q      <= idx_n;
      xor_q      <= xor_n;
      rd_ptr_q   <= rd_ptr_n;
      timer_q    <= timer_n;
      pkt_data   <= data_n;
      pkt_valid  <= valid_n;
      pkt_last   <= last_n;
      pkt_done   <= done_n;
      pkt_err    <= err_n;
      err_code   <= code_n;
      Rx_EN      <= cfg_enable;
      if (state_q == DISABLED || state_q == HUNT) begin
        baud_select <= cfg_baud;
      end
    end
  end

`ifdef UART_RX_STATS_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      stat_ok  <= '0;
      stat_err <= '0;
    end else begin
      if (done_n && stat_ok != '1)  stat_ok  <= stat_ok + 16'd1;
      if (err_n  && stat_err != '1) stat_err <= stat_err + 16'd1;
    end
  end
`else
  assign stat_ok  = '0;
  assign stat_err = '0;
`endif

endmodule

// File: tb/tb_uart_rx_packet_ctrl.sv
module tb_uart_rx_packet_ctrl;

  localparam int unsigned MAXL = 16;
  localparam int unsigned TO   = 20000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cfg_enable = 1'b0;
  logic [2:0]  cfg_baud = 3'b000;
  logic [2:0]  baud_select;
  logic        Rx_EN;
  logic [7:0]  Rx_DATA = 8'h00;
  logic        Rx_VALID = 1'b0;
  logic        Rx_FERROR = 1'b0;
  logic        Rx_PERROR = 1'b0;
  logic [7:0]  pkt_data;
  logic        pkt_valid;
  logic        pkt_ready = 1'b1;
  logic        pkt_last;
  logic        pkt_done;
  logic        pkt_err;
  logic [2:0]  err_code;
  logic [15:0] stat_ok;
  logic [15:0] stat_err;

  always #10 clock = ~clock;

  uart_rx_packet_ctrl #(
    .MAX_LEN     (MAXL),
    .SYNC_BYTE   (8'hA5),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .cfg_enable  (cfg_enable),
    .cfg_baud    (cfg_baud),
    .baud_select (baud_select),
    .Rx_EN       (Rx_EN),
    .Rx_DATA     (Rx_DATA),
    .Rx_VALID    (Rx_VALID),
    .Rx_FERROR   (Rx_FERROR),
    .Rx_PERROR   (Rx_PERROR),
    .pkt_data    (pkt_data),
    .pkt_valid   (pkt_valid),
    .pkt_ready   (pkt_ready),
    .pkt_last    (pkt_last),
    .pkt_done    (pkt_done),
    .pkt_err     (pkt_err),
    .err_code    (err_code),
    .stat_ok     (stat_ok),
    .stat_err    (stat_err)
  );

  // Output monitor, sampled on the falling edge.
  logic [7:0] beat_d [0:511];
  logic       beat_l [0:511];
  int         beat_cnt = 0;
  int         done_cnt = 0;
  int         err_cnt  = 0;
  logic [2:0] last_code = 3'd0;

  always @(negedge clock) begin
    if (pkt_valid && pkt_ready && beat_cnt < 512) begin
      beat_d[beat_cnt] <= pkt_data;
      beat_l[beat_cnt] <= pkt_last;
      beat_cnt <= beat_cnt + 1;
    end
    if (pkt_done) done_cnt <= done_cnt + 1;
    if (pkt_err) begin
      err_cnt   <= err_cnt + 1;
      last_code <= err_code;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic fe, input logic pe, input int gap);
    @(posedge clock); #1;
    Rx_DATA = d; Rx_FERROR = fe; Rx_PERROR = pe; Rx_VALID = 1'b1;
    @(posedge clock); #1;
    Rx_VALID = 1'b0; Rx_FERROR = 1'b0; Rx_PERROR = 1'b0;
    repeat (gap) @(posedge clock);
  endtask

  // Vector table: byte stream segments plus hand-computed expectations.
  typedef struct {
    int         s0, n, fe_at, pe_at;
    int         e0, ne, exp_done, exp_err;
    logic [2:0] exp_code;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] stream[$];
  logic [7:0] exp_q[$];
  int         s_mark, e_mark;

  task automatic begin_vec();
    s_mark = stream.size();
    e_mark = exp_q.size();
  endtask

  task automatic add_bytes(input int n, input logic [63:0] v);
    for (int i = 0; i < n; i++) stream.push_back(v[8*(n-1-i) +: 8]);
  endtask

  task automatic add_exp(input int n, input logic [63:0] v);
    for (int i = 0; i < n; i++) exp_q.push_back(v[8*(n-1-i) +: 8]);
  endtask

  task automatic end_vec(input int fe_at, input int pe_at, input int dn, input int er,
                         input logic [2:0] code);
    vec_t t;
    t.s0 = s_mark; t.n = stream.size() - s_mark;
    t.fe_at = fe_at; t.pe_at = pe_at;
    t.e0 = e_mark; t.ne = exp_q.size() - e_mark;
    t.exp_done = dn; t.exp_err = er; t.exp_code = code;
    vecs.push_back(t);
  endtask

  task automatic expect_deltas(input string tag, input int b0, input int d0, input int e0,
                               input int nb, input int nd, input int ne);
    chk({tag, "_beats"}, beat_cnt - b0, nb);
    chk({tag, "_done"},  done_cnt - d0, nd);
    chk({tag, "_err"},   err_cnt - e0,  ne);
  endtask

  int b0, d0, e0, seen;

  initial begin
    // V0 good 3-byte packet
    begin_vec(); add_bytes(6, 64'hA5_03_11_22_33_03); add_exp(3, 64'h11_22_33);
    end_vec(-1, -1, 1, 0, 3'd0);
    // V1 bad checksum
    begin_vec(); add_bytes(5, 64'hA5_02_AA_55_00);
    end_vec(-1, -1, 0, 1, 3'd4);
    // V2 zero-length packet
    begin_vec(); add_bytes(3, 64'hA5_00_00);
    end_vec(-1, -1, 1, 0, 3'd0);
    // V3 LEN 17 > MAX_LEN, trailing 5A ignored
    begin_vec(); add_bytes(3, 64'hA5_11_5A);
    end_vec(-1, -1, 0, 1, 3'd3);
    // V4 framing error on payload byte, then 00 FF ignored
    begin_vec(); add_bytes(6, 64'hA5_03_11_22_00_FF);
    end_vec(3, -1, 0, 1, 3'd1);
    // V5 recovery packet
    begin_vec(); add_bytes(4, 64'hA5_01_7E_7F); add_exp(1, 64'h7E);
    end_vec(-1, -1, 1, 0, 3'd0);
    // V6 parity error
    begin_vec(); add_bytes(4, 64'hA5_02_10_20);
    end_vec(-1, 3, 0, 1, 3'd2);
    // V7 framing and parity together: framing reported
    begin_vec(); add_bytes(4, 64'hA5_02_10_20);
    end_vec(3, 3, 0, 1, 3'd1);
    // V8 noise and an errored byte in HUNT, then a good packet
    begin_vec(); add_bytes(6, 64'h00_5A_A5_01_C3_C2); add_exp(1, 64'hC3);
    end_vec(0, -1, 1, 0, 3'd0);
    // V9 LEN == MAX_LEN, payload 01..10, checksum 00
    begin_vec();
    add_bytes(8, 64'hA5_10_01_02_03_04_05_06);
    add_bytes(8, 64'h07_08_09_0A_0B_0C_0D_0E);
    add_bytes(3, 64'h0F_10_00);
    add_exp(8, 64'h01_02_03_04_05_06_07_08);
    add_exp(8, 64'h09_0A_0B_0C_0D_0E_0F_10);
    end_vec(-1, -1, 1, 0, 3'd0);

    // Reset values, with enable already requested
    cfg_enable = 1'b1; cfg_baud = 3'b111;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_outputs", {Rx_EN, baud_select, pkt_valid, pkt_last, pkt_done, pkt_err, err_code, pkt_data}, 32'h0);
    chk("reset_stats", {stat_ok, stat_err}, 32'h0);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("rx_en_after_reset", Rx_EN, 1);
    chk("baud_after_reset", baud_select, 3'b111);
    repeat (2) @(posedge clock);

    foreach (vecs[v]) begin
      b0 = beat_cnt; d0 = done_cnt; e0 = err_cnt;
      for (int i = 0; i < vecs[v].n; i++)
        send_byte(stream[vecs[v].s0 + i], vecs[v].fe_at == i, vecs[v].pe_at == i, 2);
      repeat (30) @(posedge clock);
      expect_deltas($sformatf("v%0d", v), b0, d0, e0, vecs[v].ne, vecs[v].exp_done, vecs[v].exp_err);
      if (vecs[v].exp_err > 0) chk($sformatf("v%0d_code", v), last_code, vecs[v].exp_code);
      for (int i = 0; i < vecs[v].ne; i++) begin
        chk($sformatf("v%0d_beat%0d", v, i), beat_d[b0 + i], exp_q[vecs[v].e0 + i]);
        chk($sformatf("v%0d_last%0d", v, i), beat_l[b0 + i], i == vecs[v].ne - 1);
      end
    end

    // Timeout exactly TO cycles after the LEN byte event
    e0 = err_cnt;
    send_byte(8'hA5, 0, 0, 2);
    send_byte(8'h01, 0, 0, 0);
    seen = -1;
    for (int k = 1; k <= int'(TO) + 5; k++) begin
      @(posedge clock); #1;
      if (pkt_err) begin
        seen = k;
        break;
      end
    end
    chk("timeout_cycles", seen, TO);
    chk("timeout_code", err_code, 3'd5);
    repeat (3) @(posedge clock);
    chk("timeout_err_count", err_cnt - e0, 1);

    // Byte arriving on the would-be timeout edge wins
    b0 = beat_cnt; d0 = done_cnt; e0 = err_cnt;
    send_byte(8'hA5, 0, 0, 2);
    send_byte(8'h01, 0, 0, 0);
    repeat (TO - 2) @(posedge clock);
    send_byte(8'h5C, 0, 0, 2);
    send_byte(8'h5D, 0, 0, 10);
    expect_deltas("byte_wins", b0, d0, e0, 1, 1, 0);
    chk("byte_wins_beat", beat_d[b0], 8'h5C);

    // Stalled drain with an overrun byte
    b0 = beat_cnt; d0 = done_cnt; e0 = err_cnt;
    pkt_ready = 1'b0;
    send_byte(8'hA5, 0, 0, 2);
    send_byte(8'h04, 0, 0, 2);
    send_byte(8'h01, 0, 0, 2);
    send_byte(8'h02, 0, 0, 2);
    send_byte(8'h04, 0, 0, 2);
    send_byte(8'h08, 0, 0, 2);
    send_byte(8'h0B, 0, 0, 0);
    send_byte(8'hEE, 0, 0, 0);
    chk("stall_first", {pkt_valid, pkt_last, pkt_data}, {1'b1, 1'b0, 8'h01});
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      chk($sformatf("stall_hold%0d", i), {pkt_valid, pkt_data}, {1'b1, 8'h01});
    end
    @(posedge clock); #1;
    pkt_ready = 1'b1;
    repeat (12) @(posedge clock);
    expect_deltas("overrun", b0, d0, e0, 4, 1, 1);
    chk("overrun_code", last_code, 3'd6);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("overrun_beat%0d", i), beat_d[b0 + i], 8'h01 << i);
      chk($sformatf("overrun_last%0d", i), beat_l[b0 + i], i == 3);
    end

    // Disable mid-payload; baud held during the packet
    b0 = beat_cnt; d0 = done_cnt; e0 = err_cnt;
    send_byte(8'hA5, 0, 0, 2);
    send_byte(8'h04, 0, 0, 2);
    send_byte(8'h11, 0, 0, 0);
    cfg_baud = 3'b010;
    send_byte(8'h22, 0, 0, 0);
    chk("baud_held", baud_select, 3'b111);
    cfg_enable = 1'b0;
    @(posedge clock); #1;
    chk("disable_rx_en", Rx_EN, 0);
    @(posedge clock); #1;
    chk("disabled_baud", baud_select, 3'b010);
    send_byte(8'h33, 0, 0, 2);
    send_byte(8'h44, 0, 0, 2);
    cfg_baud = 3'b111;
    cfg_enable = 1'b1;
    repeat (3) @(posedge clock); #1;
    chk("reenable", {Rx_EN, baud_select}, {1'b1, 3'b111});
    send_byte(8'hA5, 0, 0, 2);
    send_byte(8'h01, 0, 0, 2);
    send_byte(8'h5A, 0, 0, 2);
    send_byte(8'h5B, 0, 0, 10);
    expect_deltas("disable", b0, d0, e0, 1, 1, 0);
    chk("disable_beat", beat_d[b0], 8'h5A);

    // Statistics so far: 8 good packets, 7 errors
`ifdef UART_RX_STATS_EN
    chk("stats_before_reset", {stat_ok, stat_err}, {16'd8, 16'd7});
`else
    chk("stats_before_reset", {stat_ok, stat_err}, 32'h0);
`endif

    // Reset mid-payload discards the partial packet
    b0 = beat_cnt; d0 = done_cnt; e0 = err_cnt;
    send_byte(8'hA5, 0, 0, 2);
    send_byte(8'h04, 0, 0, 2);
    send_byte(8'h11, 0, 0, 2);
    send_byte(8'h22, 0, 0, 0);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("midreset_outputs", {Rx_EN, baud_select, pkt_valid, pkt_last, pkt_done, pkt_err, err_code, pkt_data}, 32'h0);
    chk("midreset_stats", {stat_ok, stat_err}, 32'h0);
    reset = 1'b1;
    repeat (3) @(posedge clock);
    send_byte(8'h33, 0, 0, 2);
    send_byte(8'h44, 0, 0, 2);
    send_byte(8'h00, 0, 0, 10);
    expect_deltas("midreset_discard", b0, d0, e0, 0, 0, 0);
    b0 = beat_cnt;
    send_byte(8'hA5, 0, 0, 2);
    send_byte(8'h02, 0, 0, 2);
    send_byte(8'h01, 0, 0, 2);
    send_byte(8'h02, 0, 0, 2);
    send_byte(8'h01, 0, 0, 10);
    chk("post_reset_beats", {beat_d[b0], beat_d[b0 + 1]}, 16'h0102);
`ifdef UART_RX_STATS_EN
    chk("stats_after_reset", {stat_ok, stat_err}, {16'd1, 16'd0});
`else
    chk("stats_after_reset", {stat_ok, stat_err}, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
